// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 SDF FFT pipeline: stage state encoding,
// default data width and elaboration-time helpers.
package fft_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StFirst   = 2'b01,
    StSecond  = 2'b10,
    StWaiting = 2'b11
  } state_e;

  localparam int unsigned DefaultDw = 15;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned w = 1; w < value; w = w << 1) begin
      result++;
    end
    return result;
  endfunction

  // Half-block length L of a stage: depth of its delay line.
  function automatic int unsigned half_len(input int unsigned log2n, input int unsigned stage);
    return 32'd1 << (log2n - stage);
  endfunction

endpackage

// File: rtl/sdf_stage_ctrl.sv
// Control for one radix-2 SDF stage: registers the input onto the butterfly
// A-port, sequences fill/butterfly/drain, and issues twiddle index and markers.
module sdf_stage_ctrl
  import fft_pkg::*;
#(
  parameter int unsigned DW    = DefaultDw,
  parameter int unsigned LOG2N = 5,
  parameter int unsigned STAGE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic signed [DW-1:0] data_in_r,
  input  logic signed [DW-1:0] data_in_i,
  output logic signed [DW-1:0] data_out_r,
  output logic signed [DW-1:0] data_out_i,
  output logic [1:0]           state,
  output logic                 valid_o,
  output logic                 sop_o,
  output logic                 eop_o,
  output logic [LOG2N-2:0]     tw_idx,
  output logic                 err_o
);

  localparam int unsigned L        = half_len(LOG2N, STAGE);
  localparam int unsigned CntW     = (clog2(L) > 0) ? clog2(L) : 1;
  localparam int unsigned TwW      = LOG2N - 1;
  localparam logic [CntW-1:0] CntLast = CntW'(L - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            cont_q, cont_d;
  logic            err_q, err_d;
  logic            cnt_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_r <= '0;
      data_out_i <= '0;
    end else begin
      data_out_r <= data_in_r;
      data_out_i <= data_in_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      cont_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cont_q  <= cont_d;
      err_q   <= err_d;
    end
  end

  assign cnt_last = (cnt_q == CntLast);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cont_d  = cont_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (valid_i) begin
          state_d = StWaiting;
          cnt_d   = '0;
        end
      end
      StWaiting: begin
        // A gap anywhere in the first half, including its hand-off sample, breaks the block.
        if (!valid_i) begin
          state_d = StIdle;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else if (cnt_last) begin
          state_d = StFirst;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StFirst: begin
        if (cnt_last) begin
          state_d = StSecond;
          cnt_d   = '0;
          cont_d  = valid_i;
        end else if (!valid_i) begin
          state_d = StIdle;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StSecond: begin
        if (cnt_last) begin
          cnt_d  = '0;
          cont_d = 1'b0;
          if (!valid_i)    state_d = StIdle;
          else if (cont_q) state_d = StFirst;
          else             state_d = StWaiting;
        end else begin
          cnt_d = cnt_q + CntW'(1);
          // Either a broken continuation or a stray sample while draining alone.
          if (cont_q != valid_i) begin
            err_d  = 1'b1;
            cont_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    state   = state_q;
    valid_o = (state_q == StFirst) || (state_q == StSecond);
    sop_o   = (state_q == StFirst) && (cnt_q == '0);
    eop_o   = (state_q == StSecond) && cnt_last;
    err_o   = err_q;
    tw_idx  = '0;
    if (state_q == StSecond) begin
      tw_idx = TwW'(cnt_q) << (STAGE - 1);
    end
  end

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Bench for sdf_stage_ctrl: an L=4 and an L=1 stage share one stimulus stream and
// are compared each cycle against a block/phase-level reference model.
module tb_sdf_stage_ctrl;

  localparam int unsigned DW    = 15;
  localparam int unsigned LOG2N = 5;
  localparam int unsigned TwW   = LOG2N - 1;

  localparam int PhIdle = 0;
  localparam int PhFill = 1;
  localparam int PhSum  = 2;
  localparam int PhDiff = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 valid_i;
  logic signed [DW-1:0] data_in_r, data_in_i;

  logic signed [DW-1:0] a_dr, a_di, b_dr, b_di;
  logic [1:0]           a_state, b_state;
  logic                 a_vo, a_sop, a_eop, a_err;
  logic                 b_vo, b_sop, b_eop, b_err;
  logic [TwW-1:0]       a_tw, b_tw;

  sdf_stage_ctrl #(.DW(DW), .LOG2N(LOG2N), .STAGE(3)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .data_in_r  (data_in_r),
    .data_in_i  (data_in_i),
    .data_out_r (a_dr),
    .data_out_i (a_di),
    .state      (a_state),
    .valid_o    (a_vo),
    .sop_o      (a_sop),
    .eop_o      (a_eop),
    .tw_idx     (a_tw),
    .err_o      (a_err)
  );

  sdf_stage_ctrl #(.DW(DW), .LOG2N(LOG2N), .STAGE(5)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .data_in_r  (data_in_r),
    .data_in_i  (data_in_i),
    .data_out_r (b_dr),
    .data_out_i (b_di),
    .state      (b_state),
    .valid_o    (b_vo),
    .sop_o      (b_sop),
    .eop_o      (b_eop),
    .tw_idx     (b_tw),
    .err_o      (b_err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Per-DUT model: half length, twiddle stride, phase, cycles left in phase.
  int hl     [2] = '{4, 1};
  int stride [2] = '{4, 16};
  int ph     [2];
  int rem    [2];
  bit more   [2];
  bit err_exp[2];
  logic signed [DW-1:0] exp_r, exp_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int state_code(input int p);
    case (p)
      PhFill:  return 3;
      PhSum:   return 1;
      PhDiff:  return 2;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ph[k]      = PhIdle;
      rem[k]     = 0;
      more[k]    = 1'b0;
      err_exp[k] = 1'b0;
    end
    exp_r = '0;
    exp_i = '0;
  endtask

  task automatic model_step(input int k, input bit v);
    int l;
    l = hl[k];
    err_exp[k] = 1'b0;
    case (ph[k])
      PhIdle: if (v) begin ph[k] = PhFill; rem[k] = l; end
      PhFill: begin
        if (!v) begin ph[k] = PhIdle; err_exp[k] = 1'b1; end
        else if (rem[k] == 1) begin ph[k] = PhSum; rem[k] = l; end
        else rem[k]--;
      end
      PhSum: begin
        if (rem[k] == 1) begin ph[k] = PhDiff; rem[k] = l; more[k] = v; end
        else if (!v) begin ph[k] = PhIdle; err_exp[k] = 1'b1; end
        else rem[k]--;
      end
      default: begin
        if (rem[k] == 1) begin
          ph[k]  = !v ? PhIdle : (more[k] ? PhSum : PhFill);
          rem[k] = l;
        end else begin
          rem[k]--;
          if (more[k] != v) begin err_exp[k] = 1'b1; more[k] = 1'b0; end
        end
      end
    endcase
  endtask

  task automatic compare_dut(input int k, input string pfx, input logic [1:0] st,
                             input logic vo, input logic sop, input logic eop,
                             input logic [TwW-1:0] tw, input logic er,
                             input logic signed [DW-1:0] dr, input logic signed [DW-1:0] di);
    int pos;
    pos = hl[k] - rem[k];
    check_eq({pfx, "_state"}, 32'(st), state_code(ph[k]));
    check_eq({pfx, "_valid"}, 32'(vo), 32'(ph[k] == PhSum || ph[k] == PhDiff));
    check_eq({pfx, "_sop"}, 32'(sop), 32'(ph[k] == PhSum && pos == 0));
    check_eq({pfx, "_eop"}, 32'(eop), 32'(ph[k] == PhDiff && rem[k] == 1));
    check_eq({pfx, "_tw"}, 32'(tw), (ph[k] == PhDiff) ? pos * stride[k] : 0);
    check_eq({pfx, "_err"}, 32'(er), 32'(err_exp[k]));
    check_eq({pfx, "_dr"}, dr, exp_r);
    check_eq({pfx, "_di"}, di, exp_i);
  endtask

  task automatic check_all();
    compare_dut(0, "a", a_state, a_vo, a_sop, a_eop, a_tw, a_err, a_dr, a_di);
    compare_dut(1, "b", b_state, b_vo, b_sop, b_eop, b_tw, b_err, b_dr, b_di);
  endtask

  task automatic cycle(input bit v, input bit rnd_data);
    valid_i   = v;
    data_in_r = rnd_data ? DW'($urandom) : '0;
    data_in_i = rnd_data ? DW'($urandom) : '0;
    @(posedge clk);
    #1;
    exp_r = data_in_r;
    exp_i = data_in_i;
    model_step(0, v);
    model_step(1, v);
    check_all();
  endtask

  initial begin
    int na_sop, na_eop, nb_sop;
    bit pref;
    rst       = 1'b1;
    valid_i   = 1'b0;
    data_in_r = '0;
    data_in_i = '0;
    model_reset();
    repeat (3) begin
      @(posedge clk);
      #1;
      check_all();
    end
    rst = 1'b0;

    // Idle after reset release.
    repeat (6) cycle(1'b0, 1'b0);

    // Single 2L-sample block.
    repeat (8) cycle(1'b1, 1'b1);
    repeat (8) cycle(1'b0, 1'b1);
    check_eq("t2_back_idle", 32'(a_state), 0);

    // One continuous 32-sample frame.
    na_sop = 0; na_eop = 0; nb_sop = 0;
    repeat (32) begin
      cycle(1'b1, 1'b1);
      na_sop += int'(a_sop); na_eop += int'(a_eop); nb_sop += int'(b_sop);
    end
    repeat (8) begin
      cycle(1'b0, 1'b1);
      na_sop += int'(a_sop); na_eop += int'(a_eop); nb_sop += int'(b_sop);
    end
    check_eq("t3_sop_count", na_sop, 4);
    check_eq("t3_eop_count", na_eop, 4);
    check_eq("t5_sop_count", nb_sop, 16);

    // Gap on the third FIRST cycle of the L=4 stage.
    repeat (7) cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    check_eq("t4_err", 32'(a_err), 1);
    check_eq("t4_state", 32'(a_state), 0);
    check_eq("t4_valid", 32'(a_vo), 0);
    repeat (4) cycle(1'b0, 1'b1);

    // Asynchronous reset in SECOND with cnt=2, then a clean restart.
    repeat (11) cycle(1'b1, 1'b1);
    check_eq("t6_pre_state", 32'(a_state), 2);
    check_eq("t6_pre_tw", 32'(a_tw), 8);
    rst = 1'b1;
    #1;
    check_eq("t6_rst_state", 32'(a_state), 0);
    check_eq("t6_rst_valid", 32'(a_vo), 0);
    check_eq("t6_rst_dr", 32'(a_dr), 0);
    check_eq("t6_rst_di", 32'(a_di), 0);
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
    repeat (8) cycle(1'b1, 1'b1);
    repeat (10) cycle(1'b0, 1'b1);

    // Bursty random stream with occasional gaps inside blocks.
    pref = 1'b1;
    repeat (800) begin
      if ($urandom_range(0, 99) < 3) pref = ~pref;
      cycle(pref ? ($urandom_range(0, 63) != 0) : ($urandom_range(0, 7) == 0), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/sdf_stage_ctrl.md
Name: sdf_stage_ctrl

Overview:
Parametrised control unit for one radix-2 single-path delay-feedback (SDF) stage of an N=2^LOG2N point FFT.
- Registers the input sample onto the butterfly A-port and sequences the stage: fill delay line, butterfly, drain.
- Issues the twiddle ROM index and frame markers, and flags broken input streams.
- One instance per stage. STAGE selects half-block length L = 2^(LOG2N-STAGE).

Parameters:
DW, 15, data width per real/imag component (signed)
LOG2N, 5, log2 of FFT size; legal range 2..10
STAGE, 1, stage number 1..LOG2N; L = 2^(LOG2N-STAGE), twiddle stride S = 2^(STAGE-1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
valid_i  in  1  input sample valid; must be contiguous within a 2L-sample block
data_in_r  in  DW  input real, signed
data_in_i  in  DW  input imag, signed
data_out_r  out  DW  registered data_in_r (butterfly A-port)
data_out_i  out  DW  registered data_in_i
state  out  2  IDLE=00, FIRST=01, SECOND=10, WAITING=11; describes the role of data_out this cycle
valid_o  out  1  stage output valid (FIRST and SECOND)
sop_o  out  1  first output cycle of a block
eop_o  out  1  last output cycle of a block
tw_idx  out  LOG2N-1  twiddle ROM index into N/2-entry table
err_o  out  1  one-cycle pulse on a stream violation

Behaviour:
- Reset: state=IDLE, cnt=0, cont=0; data_out_r/i=0; valid_o/sop_o/eop_o/err_o=0; tw_idx=0.
- data_out_r/i <= data_in_r/i every cycle, unconditionally (1-cycle latency).
- cnt counts 0..L-1 within the current state; width max(1, LOG2N-STAGE).
- IDLE: if valid_i, go to WAITING with cnt=0; the sample is presented as data_out in the first WAITING cycle.
- WAITING (first-half samples fed into the delay line, valid_o=0):
  - valid_i must be 1 while cnt<L-1. If it drops, go to IDLE and pulse err_o.
  - At cnt==L-1 with valid_i=1: go to FIRST, cnt=0, valid_o<=1.
- FIRST (butterfly active; sum output, difference fed back):
  - valid_i required while cnt<L-1. If it drops, go to IDLE, valid_o<=0, pulse err_o.
  - At cnt==L-1: go to SECOND, cnt=0, cont<=valid_i (sample of the next block present or not).
- SECOND (delay-line difference × twiddle output; next-block first half enters the delay line):
  - tw_idx = cnt*S; tw_idx=0 in every other state.
  - If cont=1 and valid_i drops at cnt<L-1: pulse err_o, cont<=0, keep draining.
  - If cont=0 and valid_i=1 at cnt<L-1: ignore the sample and pulse err_o.
  - At cnt==L-1:
    - cont=1 and valid_i=1 → FIRST, cnt=0.
    - cont=0 and valid_i=1 → WAITING, cnt=0, valid_o<=0 (new frame starts cleanly).
    - valid_i=0 → IDLE, valid_o<=0.
- sop_o=1 when state==FIRST and cnt==0. eop_o=1 when state==SECOND and cnt==L-1. Both are combinational from registered state.
- L=1 (last stage): WAITING, FIRST and SECOND each last one cycle; tw_idx is always 0.
- Continuous stream: after the initial L-cycle fill, valid_o stays high and FIRST/SECOND alternate every L cycles.
- Asynchronous reset mid-operation returns to IDLE immediately. The delay-line contents are discarded by the downstream logic (valid_o=0).

Decomposition:
- Shared package fft_pkg holds:
  - state encodings IDLE/FIRST/SECOND/WAITING
  - default DW
  - constant functions clog2 and half_len(LOG2N,STAGE)
- No sub-module; counter, FSM and twiddle index live in one module.
- The delay line and butterfly are separate existing blocks driven by state.

Test Plan:
1. LOG2N=5, STAGE=3 (L=4); rst held, then released, no valid_i → all outputs 0, state=IDLE indefinitely.
2. L=4; one 8-sample block, valid_i high 8 cycles → WAITING cycles 1-4; FIRST cycles 5-8 with sop_o at cycle 5; SECOND cycles 9-12 with tw_idx 0,4,8,12 and eop_o at cycle 12; IDLE at cycle 13; err_o never asserted.
3. L=4; valid_i high 32 cycles (one frame) → valid_o high cycles 5-36; FIRST/SECOND alternate every 4 cycles; 4 sop_o and 4 eop_o pulses.
4. L=4; valid_i drops at 3rd FIRST cycle → err_o pulse next cycle; state=IDLE; valid_o=0.
5. STAGE=5 (L=1), continuous valid_i → state sequence WAITING, FIRST, SECOND, FIRST, …; tw_idx always 0; sop_o/eop_o alternate each cycle.
6. L=4; rst asserted during SECOND cnt=2 → same cycle state=IDLE, valid_o=0, data_out=0; restart works normally.
